frame_draw_sequencer: RTL and testbench

//  Initiator/sink end of the sprite draw handshake (draw / draw_done + x_draw, y_draw, colour, VGA_write).
//  On each frame_start, raises draw to each enabled client in index order (map, link, enemies, HUD).

---
 rtl/draw_pkg.sv | 27 ++
 rtl/draw_client_mux.sv | 44 ++++
 rtl/frame_draw_sequencer.sv | 162 ++++++++++++++++
 tb/tb_frame_draw_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// ---------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the sprite draw handshake: sequencer FSM encoding,
// default pixel/colour widths (also used by the link and enemy draw blocks),
// watchdog width and ON/OFF strobe constants.
// ---------------------------------------------------------------------------
package draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_DRAW,
        ST_RELEASE,
        ST_FINISH
    } draw_state_t;

    localparam int X_W_DEF = 9;
    localparam int Y_W_DEF = 8;
    localparam int C_W_DEF = 6;

    // Per-client watchdog width; TIMEOUT_CYCLES must fit below 2^WD_W.
    localparam int WD_W = 17;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

endpackage

// File: rtl/draw_client_mux.sv
// ---------------------------------------------------------------------------
// draw_client_mux
// Combinational N:1 select of one client's pixel write by index.
// Ports:
//   idx            in  IDX_W          selected client (>= NUM_CLIENTS selects none)
//   client_x/y/colour in packed       client i at [i*W +: W]
//   client_write   in  NUM_CLIENTS    per-client write strobe
//   sel_x/y/colour out                selected client's pixel, 0 when none
//   sel_write      out 1              selected client's strobe, 0 when none
// ---------------------------------------------------------------------------
module draw_client_mux import draw_pkg::*; #(
    parameter int NUM_CLIENTS = 4,
    parameter int X_W         = X_W_DEF,
    parameter int Y_W         = Y_W_DEF,
    parameter int C_W         = C_W_DEF,
    parameter int IDX_W       = $clog2(NUM_CLIENTS + 1)
) (
    input  logic [IDX_W-1:0]           idx,
    input  logic [NUM_CLIENTS*X_W-1:0] client_x,
    input  logic [NUM_CLIENTS*Y_W-1:0] client_y,
    input  logic [NUM_CLIENTS*C_W-1:0] client_colour,
    input  logic [NUM_CLIENTS-1:0]     client_write,
    output logic [X_W-1:0]             sel_x,
    output logic [Y_W-1:0]             sel_y,
    output logic [C_W-1:0]             sel_colour,
    output logic                       sel_write
);

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_write  = OFF;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_x      = client_x[i*X_W +: X_W];
                sel_y      = client_y[i*Y_W +: Y_W];
                sel_colour = client_colour[i*C_W +: C_W];
                sel_write  = client_write[i];
            end
        end
    end

endmodule

// File: rtl/frame_draw_sequencer.sv
// ---------------------------------------------------------------------------
// frame_draw_sequencer
// On frame_start, raises draw to each enabled client in index order, waits
// for its draw_done (or a watchdog abort), forwards the selected client's
// pixel writes onto one registered VGA write port, then pulses frame_done.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   frame_start         pulse: begin a pass (ignored while busy)
//   client_enable       per-client enable mask, latched at accepted frame_start
//   client_draw         one-hot draw request to the active client
//   client_done         per-client draw_done level
//   client_x/y/colour   packed per-client pixel, client i at [i*W +: W]
//   client_write        per-client pixel write strobe
//   vga_x/y/colour/plot registered pixel write toward the VGA adapter
//   busy                high from accepted frame_start through frame_done
//   frame_done          single-cycle end-of-pass pulse
//   timeout_flags       sticky per pass: client i was aborted by the watchdog
// ---------------------------------------------------------------------------
module frame_draw_sequencer import draw_pkg::*; #(
    parameter int NUM_CLIENTS    = 4,
    parameter int X_W            = X_W_DEF,
    parameter int Y_W            = Y_W_DEF,
    parameter int C_W            = C_W_DEF,
    parameter int TIMEOUT_CYCLES = 131071
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic [NUM_CLIENTS-1:0]     client_enable,
    output logic [NUM_CLIENTS-1:0]     client_draw,
    input  logic [NUM_CLIENTS-1:0]     client_done,
    input  logic [NUM_CLIENTS*X_W-1:0] client_x,
    input  logic [NUM_CLIENTS*Y_W-1:0] client_y,
    input  logic [NUM_CLIENTS*C_W-1:0] client_colour,
    input  logic [NUM_CLIENTS-1:0]     client_write,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [C_W-1:0]             vga_colour,
    output logic                       vga_plot,
    output logic                       busy,
    output logic                       frame_done,
    output logic [NUM_CLIENTS-1:0]     timeout_flags
);

    localparam int              IDX_W   = $clog2(NUM_CLIENTS + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    draw_state_t            state, state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [NUM_CLIENTS-1:0] mask;
    logic [WD_W-1:0]        wd;

    logic [NUM_CLIENTS-1:0] sel_oh;
    logic                   sel_enabled, sel_done, idx_end, wd_expired;

    logic [X_W-1:0]         pix_x_p0;
    logic [Y_W-1:0]         pix_y_p0;
    logic [C_W-1:0]         pix_colour_p0;
    logic                   pix_write_p0;

    // One-hot of the current index; all zero once idx has run past the last client.
    always_comb begin
        sel_oh      = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << idx;
        sel_enabled = |(mask & sel_oh);
        sel_done    = |(client_done & sel_oh);
        idx_end     = (idx == IDX_W'(NUM_CLIENTS));
        wd_expired  = (wd == WD_LAST);
    end

    always_comb begin
        state_nxt   = state;
        client_draw = '0;
        frame_done  = OFF;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE:    if (frame_start) state_nxt = ST_SELECT;
            ST_SELECT: begin
                if (idx_end)          state_nxt = ST_FINISH;
                else if (sel_enabled) state_nxt = ST_DRAW;
            end
            ST_DRAW: begin
                client_draw = sel_oh;
                if (sel_done || wd_expired) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: state_nxt = ST_SELECT;
            ST_FINISH: begin
                frame_done = ON;
                state_nxt  = ST_IDLE;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            mask          <= '0;
            wd            <= '0;
            timeout_flags <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        mask          <= client_enable;
                        timeout_flags <= '0;
                        idx           <= '0;
                    end
                end
                ST_SELECT: begin
                    wd <= '0;
                    if (!idx_end && !sel_enabled) idx <= idx + IDX_W'(1);
                end
                ST_DRAW: begin
                    wd <= wd + WD_W'(1);
                    // A done seen on the expiry cycle still counts as a clean finish.
                    if (!sel_done && wd_expired) timeout_flags <= timeout_flags | sel_oh;
                end
                ST_RELEASE: idx <= idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Stage p0: combinational select of the active client's write.
    draw_client_mux #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .X_W         (X_W),
        .Y_W         (Y_W),
        .C_W         (C_W),
        .IDX_W       (IDX_W)
    ) u_mux (
        .idx           (idx),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_colour (client_colour),
        .client_write  (client_write),
        .sel_x         (pix_x_p0),
        .sel_y         (pix_y_p0),
        .sel_colour    (pix_colour_p0),
        .sel_write     (pix_write_p0)
    );

    // Stage p1: registered VGA port; coordinates hold their last value outside DRAW.
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= OFF;
        end else if (state == ST_DRAW) begin
            vga_x      <= pix_x_p0;
            vga_y      <= pix_y_p0;
            vga_colour <= pix_colour_p0;
            vga_plot   <= pix_write_p0;
        end else begin
            vga_plot   <= OFF;
        end
    end

endmodule

// File: tb/tb_frame_draw_sequencer.sv
module tb_frame_draw_sequencer;

    localparam int N     = 4;
    localparam int XW    = 9;
    localparam int YW    = 8;
    localparam int CW    = 6;
    localparam int T     = 16;
    localparam int MAXC  = 16384;
    localparam int NEVER = 1 << 30;

    logic            clock = 1'b0;
    logic            reset, frame_start;
    logic [N-1:0]    client_enable, client_draw, client_done, client_write, timeout_flags;
    logic [N*XW-1:0] client_x;
    logic [N*YW-1:0] client_y;
    logic [N*CW-1:0] client_colour;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [CW-1:0]   vga_colour;
    logic            vga_plot, busy, frame_done;

    frame_draw_sequencer #(
        .NUM_CLIENTS(N), .X_W(XW), .Y_W(YW), .C_W(CW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .client_enable(client_enable), .client_draw(client_draw),
        .client_done(client_done), .client_x(client_x), .client_y(client_y),
        .client_colour(client_colour), .client_write(client_write),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .frame_done(frame_done), .timeout_flags(timeout_flags)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference timeline: what each cycle should look like, computed per pass.
    logic [N-1:0] exp_draw [MAXC];
    bit           exp_busy [MAXC];
    bit           exp_fdone[MAXC];
    logic [N-1:0] exp_flags;

    typedef struct { int c; int x; int y; int col; } pix_t;
    pix_t sbq[$];

    int d[N];
    int cnt[N];
    bit wr_all, t6;
    int total = 0, bad = 0;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, expv);
        end
    endtask

    // A pass accepted in cycle t: SELECT from t+1, each enabled client drawn
    // min(d+1, T) cycles followed by one release cycle, FINISH after idx runs out.
    function automatic void model_accept(input int t, input logic [N-1:0] m);
        int c = t + 1;
        int len;
        exp_flags = '0;
        for (int i = 0; i < N; i++) begin
            if (!m[i]) c++;
            else begin
                len = (d[i] <= T - 1) ? d[i] + 1 : T;
                if (d[i] > T - 1) exp_flags[i] = 1'b1;
                for (int k = 1; k <= len; k++) exp_draw[c + k] = N'(1) << i;
                c += len + 2;
            end
        end
        exp_fdone[c + 1] = 1'b1;
        for (int k = t + 1; k <= c + 1; k++) exp_busy[k] = 1'b1;
    endfunction

    function automatic void model_reset(input int n);
        pix_t keep[$];
        for (int k = n + 1; k < MAXC; k++) begin
            exp_draw[k] = '0; exp_busy[k] = 1'b0; exp_fdone[k] = 1'b0;
        end
        foreach (sbq[j]) if (sbq[j].c <= n) keep.push_back(sbq[j]);
        sbq = keep;
        exp_flags = '0;
    endfunction

    // One cycle of stimulus: control inputs plus behavioural client models.
    task automatic tick(input bit fs, input bit rst, input logic [N-1:0] en, input bit fs_if_busy);
        logic [N-1:0]    dn, wr;
        logic [N*XW-1:0] xs;
        logic [N*YW-1:0] ys;
        logic [N*CW-1:0] cs;
        int x, y, col;
        @(negedge clock);
        if (fs_if_busy && exp_busy[cyc]) fs = 1'b1;
        reset = rst; frame_start = fs; client_enable = en;
        if (rst) model_reset(cyc);
        else if (fs && !exp_busy[cyc]) model_accept(cyc, en);
        for (int i = 0; i < N; i++) begin
            x = int'($urandom_range(0, 511)); y = int'($urandom_range(0, 255));
            col = int'($urandom_range(0, 63));
            wr[i] = wr_all ? 1'b1 : 1'($urandom_range(0, 1));
            if (client_draw[i]) begin
                dn[i] = (cnt[i] >= d[i]);
                cnt[i]++;
            end else begin
                dn[i] = 1'b0;
                cnt[i] = 0;
            end
            if (t6 && i == 3 && dn[i]) begin
                x = 319; y = 239; col = 63; wr[i] = 1'b1;
            end
            xs[i*XW +: XW] = XW'(x); ys[i*YW +: YW] = YW'(y); cs[i*CW +: CW] = CW'(col);
            if (!rst && exp_draw[cyc][i] && wr[i]) sbq.push_back('{cyc + 1, x, y, col});
        end
        client_done = dn; client_write = wr;
        client_x = xs; client_y = ys; client_colour = cs;
    endtask

    task automatic wait_idle(input bit rnd_pulse, output int ndone);
        bit ok = 1'b0;
        ndone = 0;
        for (int k = 0; k < 600; k++) begin
            tick(1'b0, 1'b0, N'($urandom), rnd_pulse && ($urandom_range(0, 7) == 0));
            if (frame_done) ndone++;
            if (!exp_busy[cyc]) begin ok = 1'b1; break; end
        end
        if (!ok) chk("pass_bound", 0, 1);
        tick(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic run_frame(input logic [N-1:0] m, input bit rnd_pulse);
        int nd;
        tick(1'b1, 1'b0, m, 1'b0);
        wait_idle(rnd_pulse, nd);
        chk("frame_done_count", nd, 1);
    endtask

    // Monitor: compares every cycle against the timeline and the pixel scoreboard.
    initial begin
        pix_t p;
        forever begin
            @(negedge clock);
            if (cyc >= 1 && cyc < MAXC) begin
                chk("client_draw", int'(client_draw), int'(exp_draw[cyc]));
                chk("busy", int'(busy), int'(exp_busy[cyc]));
                chk("frame_done", int'(frame_done), int'(exp_fdone[cyc]));
                if (exp_fdone[cyc]) chk("timeout_flags", int'(timeout_flags), int'(exp_flags));
                if (sbq.size() > 0 && sbq[0].c == cyc) begin
                    p = sbq.pop_front();
                    chk("vga_plot", int'(vga_plot), 1);
                    chk("vga_x", int'(vga_x), p.x);
                    chk("vga_y", int'(vga_y), p.y);
                    chk("vga_colour", int'(vga_colour), p.col);
                end else begin
                    chk("vga_plot_idle", int'(vga_plot), 0);
                end
            end
        end
    end

    initial begin
        int t0, seen, nd;
        bit ok;
        reset = 1'b1; frame_start = 1'b0; client_enable = '0; client_done = '0;
        client_write = '0; client_x = '0; client_y = '0; client_colour = '0;
        wr_all = 1'b0; t6 = 1'b0;
        for (int i = 0; i < N; i++) begin d[i] = 0; cnt[i] = 0; end
        repeat (3) tick(1'b0, 1'b1, '0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        chk("reset_vga_x", int'(vga_x), 0);
        chk("reset_vga_y", int'(vga_y), 0);
        chk("reset_vga_colour", int'(vga_colour), 0);
        chk("reset_flags", int'(timeout_flags), 0);

        // All clients, done after 10 cycles, writing every cycle.
        d = '{9, 9, 9, 9}; wr_all = 1'b1;
        run_frame(4'b1111, 1'b0);
        chk("t1_flags", int'(timeout_flags), 0);

        // Sparse mask: clients 1 and 3 write but are never selected.
        for (int i = 0; i < N; i++) d[i] = int'($urandom_range(0, 8));
        run_frame(4'b0101, 1'b0);

        // Hung client 1 aborted by the watchdog.
        d = '{3, NEVER, 4, 2}; wr_all = 1'b0;
        run_frame(4'b1111, 1'b0);
        chk("t3_flags", int'(timeout_flags), 4'b0010);

        // Done on the exact expiry cycle.
        d = '{T - 1, 0, 0, 0};
        run_frame(4'b0001, 1'b0);
        chk("t4_flags", int'(timeout_flags), 0);

        // Empty mask latency.
        tick(1'b1, 1'b0, '0, 1'b0);
        t0 = cyc; seen = -1;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            if (frame_done) begin seen = cyc; break; end
        end
        chk("mask0_latency", seen - t0, N + 2);
        tick(1'b0, 1'b0, '0, 1'b0);

        // Re-pulsed frame_start during client 2 is ignored.
        d = '{5, 5, 5, 5};
        tick(1'b1, 1'b0, 4'hF, 1'b0);
        ok = 1'b0; nd = 0;
        for (int k = 0; k < 200; k++) begin
            tick(1'b0, 1'b0, 4'hF, 1'b0);
            if (frame_done) nd++;
            if (exp_draw[cyc] == 4'b0100) begin ok = 1'b1; break; end
        end
        chk("t5_reach_client2", int'(ok), 1);
        tick(1'b1, 1'b0, 4'hF, 1'b0);
        wait_idle(1'b0, seen);
        chk("t5_single_done", nd + seen, 1);

        // Reset mid-DRAW of client 2 after client 1 timed out.
        d = '{3, NEVER, 5, 5};
        tick(1'b1, 1'b0, 4'hF, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick(1'b0, 1'b0, 4'hF, 1'b0);
            if (exp_draw[cyc] == 4'b0100) begin ok = 1'b1; break; end
        end
        chk("t5b_reach_client2", int'(ok), 1);
        tick(1'b0, 1'b1, 4'hF, 1'b0);
        tick(1'b0, 1'b0, 4'hF, 1'b0);
        chk("rst_draw", int'(client_draw), 0);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_flags", int'(timeout_flags), 0);
        repeat (2) tick(1'b0, 1'b0, '0, 1'b0);

        // Client 3 writes a corner pixel in its done cycle.
        d = '{0, 0, 0, 4}; t6 = 1'b1; wr_all = 1'b0;
        run_frame(4'b1000, 1'b0);
        t6 = 1'b0;
        chk("t6_hold_x", int'(vga_x), 319);
        chk("t6_hold_y", int'(vga_y), 239);
        chk("t6_hold_colour", int'(vga_colour), 63);
        chk("t6_plot_low", int'(vga_plot), 0);

        // Random passes with stray frame_start pulses while busy.
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) d[i] = int'($urandom_range(0, 20));
            wr_all = 1'($urandom_range(0, 1));
            run_frame(N'($urandom), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
